// File: rtl/sweep_step_tracker.sv
// Step timer and per-axis peak tracker for the servo sweep FSM.
// Optional hysteresis on new maxima when MAX_HYST_EN is defined.
module sweep_step_tracker #(
  parameter int unsigned STEP_DIV    = 50000,
  parameter int unsigned SWEEP_STEPS = 180,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned HYST        = 8
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               HS,
  input  logic                               VS,
  input  logic                               MC,
  input  logic                               CNT_RST,
  input  logic [DATA_W-1:0]                  ADC_DATA,
  output logic                               CNT_L,
  output logic                               CNT_RU,
  output logic                               CNT_D,
  output logic                               STEP_TICK,
  output logic [$clog2(SWEEP_STEPS+1)-1:0]   MAX_H_POS,
  output logic [$clog2(SWEEP_STEPS+1)-1:0]   MAX_V_POS,
  output logic [DATA_W-1:0]                  MAX_VAL
);

  localparam int unsigned CW = $clog2(SWEEP_STEPS + 1);
  localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [CW-1:0] STEPS_LAST = CW'(SWEEP_STEPS);

`ifdef MAX_HYST_EN
  localparam int unsigned HYST_EFF = HYST;
`else
  // Hysteresis disabled: margin collapses to zero (plain strict compare).
  localparam int unsigned HYST_EFF = HYST * 0;
`endif

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_H    = 2'd1,
    PH_V    = 2'd2,
    PH_RET  = 2'd3
  } phase_e;

  phase_e            phase;
  logic              h_done_q, h_done_d;
  logic              v_done_q, v_done_d;
  logic [CW-1:0]     step_cnt_q, step_cnt_d;
  logic [CW-1:0]     ret_cnt_q, ret_cnt_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [DATA_W-1:0] max_val_q, max_val_d;
  logic [CW-1:0]     max_pos_q, max_pos_d;
  logic [CW-1:0]     max_h_pos_q, max_h_pos_d;
  logic [CW-1:0]     max_v_pos_q, max_v_pos_d;
  logic              tick_q, tick_d;

  // Single active phase, fixed priority H > V > return.
  always_comb begin
    phase = PH_IDLE;
    if (HS && !h_done_q) begin
      phase = PH_H;
    end else if (VS && h_done_q && !v_done_q) begin
      phase = PH_V;
    end else if (MC && (ret_cnt_q != '0)) begin
      phase = PH_RET;
    end
  end

  // Prescaler, sweep stepping with peak capture, and return countdown.
  always_comb begin
    logic [CW-1:0]     k;
    logic              load;
    logic              v_first;
    logic [DATA_W-1:0] base_val;
    logic [CW-1:0]     base_pos;

    h_done_d    = h_done_q;
    v_done_d    = v_done_q;
    step_cnt_d  = step_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    presc_d     = presc_q;
    max_h_pos_d = max_h_pos_q;
    max_v_pos_d = max_v_pos_q;
    tick_d      = 1'b0;
    k           = '0;
    load        = 1'b0;

    if (phase == PH_IDLE) begin
      presc_d = '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // Vertical sweep starts from a clean maximum; horizontal result is kept.
    v_first  = (phase == PH_V) && (step_cnt_q == '0) && (presc_q == '0);
    base_val = v_first ? '0 : max_val_q;
    base_pos = v_first ? '0 : max_pos_q;
    max_val_d = base_val;
    max_pos_d = base_pos;

    if (tick_d && ((phase == PH_H) || (phase == PH_V))) begin
      k          = step_cnt_q + CW'(1);
      step_cnt_d = k;
      load = ({1'b0, ADC_DATA} > ({1'b0, base_val} + (DATA_W + 1)'(HYST_EFF)));
`ifdef MAX_HYST_EN
      if (step_cnt_q == '0) begin
        load = 1'b1;
      end
`endif
      if (load) begin
        max_val_d = ADC_DATA;
        max_pos_d = k;
      end
      if (k == STEPS_LAST) begin
        step_cnt_d = '0;
        ret_cnt_d  = STEPS_LAST - max_pos_d;
        if (phase == PH_H) begin
          h_done_d    = 1'b1;
          max_h_pos_d = max_pos_d;
        end else begin
          v_done_d    = 1'b1;
          max_v_pos_d = max_pos_d;
        end
      end
    end else if (tick_d && (phase == PH_RET)) begin
      ret_cnt_d = ret_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || CNT_RST) begin
      h_done_q    <= 1'b0;
      v_done_q    <= 1'b0;
      step_cnt_q  <= '0;
      ret_cnt_q   <= '0;
      presc_q     <= '0;
      max_val_q   <= '0;
      max_pos_q   <= '0;
      max_h_pos_q <= '0;
      max_v_pos_q <= '0;
      tick_q      <= 1'b0;
    end else begin
      h_done_q    <= h_done_d;
      v_done_q    <= v_done_d;
      step_cnt_q  <= step_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      presc_q     <= presc_d;
      max_val_q   <= max_val_d;
      max_pos_q   <= max_pos_d;
      max_h_pos_q <= max_h_pos_d;
      max_v_pos_q <= max_v_pos_d;
      tick_q      <= tick_d;
    end
  end

  // Status flags decode straight from registers so the FSM sees them this cycle.
  assign CNT_L     = ~h_done_q;
  assign CNT_D     = ~v_done_q;
  assign CNT_RU    = (ret_cnt_q != '0);
  assign STEP_TICK = tick_q;
  assign MAX_H_POS = max_h_pos_q;
  assign MAX_V_POS = max_v_pos_q;
  assign MAX_VAL   = max_val_q;

endmodule

// File: tb/tb_sweep_step_tracker.sv
// Randomized bench for sweep_step_tracker with a sample-array peak model.
module tb_sweep_step_tracker;

  localparam int unsigned SD = 4;
  localparam int unsigned SS = 8;
  localparam int unsigned DW = 12;
  localparam int unsigned CW = $clog2(SS + 1);

  logic          CLK = 1'b0;
  logic          RST, HS, VS, MC, CNT_RST;
  logic [DW-1:0] ADC_DATA;
  logic          CNT_L, CNT_RU, CNT_D, STEP_TICK;
  logic [CW-1:0] MAX_H_POS, MAX_V_POS;
  logic [DW-1:0] MAX_VAL;

  int checks = 0;
  int errors = 0;

  sweep_step_tracker #(
    .STEP_DIV(SD), .SWEEP_STEPS(SS), .DATA_W(DW), .HYST(8)
  ) dut (
    .CLK(CLK), .RST(RST), .HS(HS), .VS(VS), .MC(MC), .CNT_RST(CNT_RST),
    .ADC_DATA(ADC_DATA), .CNT_L(CNT_L), .CNT_RU(CNT_RU), .CNT_D(CNT_D),
    .STEP_TICK(STEP_TICK), .MAX_H_POS(MAX_H_POS), .MAX_V_POS(MAX_V_POS),
    .MAX_VAL(MAX_VAL)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Peak of a sample list: first index holding the largest value (1-based, 0 if none).
  function automatic void model(input int s[SS], output int pos, output int val);
    bit load;
    pos = 0;
    val = 0;
    for (int k = 1; k <= int'(SS); k++) begin
`ifdef MAX_HYST_EN
      load = (k == 1) || (s[k-1] > val + 8);
`else
      load = s[k-1] > val;
`endif
      if (load) begin
        val = s[k-1];
        pos = k;
      end
    end
  endfunction

  task automatic do_reset();
    RST = 1'b1; HS = 1'b0; VS = 1'b0; MC = 1'b0; CNT_RST = 1'b0; ADC_DATA = '0;
    cyc();
    cyc();
    RST = 1'b0;
  endtask

  // Full sweep on one axis; checks tick timing, done timing and captured peak.
  task automatic do_sweep(input bit vert, input int s[SS], input bit both,
                          input int exp_hpos, output int ret);
    int pos, val;
    bit pend;
    model(s, pos, val);
    ret = int'(SS) - pos;
    if (vert) VS = 1'b1;
    else begin HS = 1'b1; VS = both; end
    ADC_DATA = DW'(s[0]);
    for (int c = 1; c <= int'(SD * SS); c++) begin
      cyc();
      checks++;
      if (STEP_TICK !== (c % SD == 0)) begin
        errors++;
        $display("FAIL sweep_tick v=%0d c=%0d got %b exp %b", vert, c, STEP_TICK, (c % SD == 0));
      end
      pend = vert ? CNT_D : CNT_L;
      checks++;
      if (pend !== (c < int'(SD * SS))) begin
        errors++;
        $display("FAIL sweep_pending v=%0d c=%0d got %b exp %b", vert, c, pend, (c < int'(SD * SS)));
      end
      if (vert && c == 1) begin
        checks++;
        if (MAX_VAL !== '0) begin
          errors++;
          $display("FAIL v_start_clear got %0d exp 0", MAX_VAL);
        end
      end
      if (c % SD == 0 && c < int'(SD * SS)) ADC_DATA = DW'(s[c / SD]);
    end
    HS = 1'b0;
    VS = 1'b0;
    checks++;
    if (MAX_VAL !== DW'(val)) begin
      errors++;
      $display("FAIL max_val v=%0d got %0d exp %0d", vert, MAX_VAL, val);
    end
    checks++;
    if ((vert ? MAX_V_POS : MAX_H_POS) !== CW'(pos)) begin
      errors++;
      $display("FAIL peak_pos v=%0d got %0d exp %0d", vert, (vert ? MAX_V_POS : MAX_H_POS), pos);
    end
    checks++;
    if (CNT_RU !== (ret != 0)) begin
      errors++;
      $display("FAIL cnt_ru_after_sweep got %b exp %b", CNT_RU, (ret != 0));
    end
    if (vert) begin
      checks++;
      if (MAX_H_POS !== CW'(exp_hpos)) begin
        errors++;
        $display("FAIL h_pos_retained got %0d exp %0d", MAX_H_POS, exp_hpos);
      end
    end
  endtask

  // Return to peak: ret ticks then CNT_RU low and no further ticks.
  task automatic do_return(input int ret);
    MC = 1'b1;
    for (int c = 1; c <= int'(SD) * (ret + 1); c++) begin
      cyc();
      checks++;
      if (STEP_TICK !== (c % SD == 0 && c <= int'(SD) * ret)) begin
        errors++;
        $display("FAIL ret_tick c=%0d got %b exp %b", c, STEP_TICK, (c % SD == 0 && c <= int'(SD) * ret));
      end
      checks++;
      if (CNT_RU !== (c < int'(SD) * ret)) begin
        errors++;
        $display("FAIL ret_pending c=%0d got %b exp %b", c, CNT_RU, (c < int'(SD) * ret));
      end
    end
    MC = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      cyc();
      checks++;
      if ({CNT_L, CNT_D, CNT_RU, STEP_TICK} !== 4'b1100 || MAX_VAL !== '0 ||
          MAX_H_POS !== '0 || MAX_V_POS !== '0) begin
        errors++;
        $display("FAIL reset_state got L%b D%b RU%b T%b val %0d h %0d v %0d",
                 CNT_L, CNT_D, CNT_RU, STEP_TICK, MAX_VAL, MAX_H_POS, MAX_V_POS);
      end
    end
    VS = 1'b1;
    for (int c = 0; c < 2 * int'(SD); c++) begin
      cyc();
      checks++;
      if (STEP_TICK !== 1'b0 || CNT_D !== 1'b1) begin
        errors++;
        $display("FAIL vs_before_h got tick %b cnt_d %b exp 0 1", STEP_TICK, CNT_D);
      end
    end
    VS = 1'b0;
  endtask

  task automatic test_directed();
    int s[SS];
    int s2[SS];
    int ret;
    do_reset();
    s = '{10, 20, 90, 40, 90, 5, 5, 5};
    do_sweep(1'b0, s, 1'b0, 0, ret);
    checks++;
    if (MAX_H_POS !== CW'(3) || MAX_VAL !== DW'(90)) begin
      errors++;
      $display("FAIL directed_h got pos %0d val %0d exp 3 90", MAX_H_POS, MAX_VAL);
    end
    do_return(ret);
    for (int i = 0; i < int'(SS) - 1; i++) s2[i] = int'($urandom_range(0, 299));
    s2[SS-1] = 300;
    do_sweep(1'b1, s2, 1'b0, 3, ret);
    checks++;
    if (MAX_V_POS !== CW'(8) || CNT_D !== 1'b0) begin
      errors++;
      $display("FAIL directed_v got pos %0d cnt_d %b exp 8 0", MAX_V_POS, CNT_D);
    end
    do_return(0);
    HS = 1'b1; VS = 1'b1; MC = 1'b1;
    for (int c = 0; c < 2 * int'(SD); c++) begin
      cyc();
      checks++;
      if (STEP_TICK !== 1'b0) begin
        errors++;
        $display("FAIL quiescent_tick c=%0d got %b exp 0", c, STEP_TICK);
      end
    end
    HS = 1'b0; VS = 1'b0; MC = 1'b0;
  endtask

  task automatic test_cnt_rst();
    int s[SS];
    int ret;
    do_reset();
    for (int i = 0; i < int'(SS); i++) s[i] = int'($urandom_range(1, 4000));
    do_sweep(1'b0, s, 1'b0, 0, ret);
    VS = 1'b1;
    ADC_DATA = DW'(777);
    for (int c = 0; c < 4 * int'(SD); c++) cyc();
    VS = 1'b0;
    CNT_RST = 1'b1;
    cyc();
    CNT_RST = 1'b0;
    checks++;
    if ({CNT_L, CNT_D, CNT_RU, STEP_TICK} !== 4'b1100 || MAX_VAL !== '0 ||
        MAX_H_POS !== '0 || MAX_V_POS !== '0) begin
      errors++;
      $display("FAIL cnt_rst_state got L%b D%b RU%b T%b val %0d h %0d v %0d",
               CNT_L, CNT_D, CNT_RU, STEP_TICK, MAX_VAL, MAX_H_POS, MAX_V_POS);
    end
    for (int i = 0; i < int'(SS); i++) s[i] = int'($urandom_range(0, 4095));
    do_sweep(1'b0, s, 1'b0, 0, ret);
  endtask

  task automatic test_enable_drop();
    do_reset();
    ADC_DATA = DW'(50);
    HS = 1'b1;
    for (int c = 1; c <= int'(SD) + 2; c++) begin
      cyc();
      checks++;
      if (STEP_TICK !== (c == int'(SD))) begin
        errors++;
        $display("FAIL drop_pre_tick c=%0d got %b exp %b", c, STEP_TICK, (c == int'(SD)));
      end
    end
    HS = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      checks++;
      if (STEP_TICK !== 1'b0 || CNT_L !== 1'b1) begin
        errors++;
        $display("FAIL drop_idle got tick %b cnt_l %b exp 0 1", STEP_TICK, CNT_L);
      end
    end
    HS = 1'b1;
    for (int c = 1; c <= int'(SD * (SS - 1)); c++) begin
      cyc();
      checks++;
      if (STEP_TICK !== (c % SD == 0) || CNT_L !== (c < int'(SD * (SS - 1)))) begin
        errors++;
        $display("FAIL drop_resume c=%0d got tick %b cnt_l %b exp %b %b", c, STEP_TICK, CNT_L,
                 (c % SD == 0), (c < int'(SD * (SS - 1))));
      end
    end
    HS = 1'b0;
    checks++;
    if (MAX_H_POS !== CW'(1) || MAX_VAL !== DW'(50)) begin
      errors++;
      $display("FAIL drop_tie_pos got pos %0d val %0d exp 1 50", MAX_H_POS, MAX_VAL);
    end
  endtask

  task automatic test_all_zero();
    int s[SS];
    int ret;
    do_reset();
    for (int i = 0; i < int'(SS); i++) s[i] = 0;
    do_sweep(1'b0, s, 1'b0, 0, ret);
    checks++;
    if (ret != int'(SS) || MAX_H_POS !== '0) begin
      errors++;
      $display("FAIL all_zero got pos %0d ret %0d exp 0 %0d", MAX_H_POS, ret, SS);
    end
    do_return(ret);
  endtask

  task automatic test_random();
    int sh[SS];
    int sv[SS];
    int hpos, hval, ret;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      for (int i = 0; i < int'(SS); i++) begin
        sh[i] = (it % 2 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4095));
        sv[i] = (it % 2 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4095));
      end
      model(sh, hpos, hval);
      do_sweep(1'b0, sh, 1'($urandom_range(0, 1)), 0, ret);
      do_return(ret);
      do_sweep(1'b1, sv, 1'b0, hpos, ret);
      do_return(ret);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_cnt_rst();
    test_enable_drop();
    test_all_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sweep_step_tracker.md
Name: sweep_step_tracker

Overview:
- Counter/maximum-tracker that answers the tracker control FSM's sweep enables.
- Consumes HS, VS, MC and CNT_RST from the FSM plus a light-intensity sample stream. Drives CNT_L, CNT_RU and CNT_D back to the FSM.
- Times each servo step, records the step index of peak intensity per axis, then counts the return steps to that peak.

Parameters:
- STEP_DIV, 50000: CLK cycles per servo step; must be >= 1.
- SWEEP_STEPS, 180: servo steps in one full sweep per axis; must be >= 1.
- DATA_W, 12: intensity sample width.
- HYST, 8: hysteresis margin used only when MAX_HYST_EN is defined.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous active-high reset
- HS  input  1  horizontal sweep enable
- VS  input  1  vertical sweep enable
- MC  input  1  return-to-maximum enable
- CNT_RST  input  1  synchronous clear from FSM; same effect as RST
- ADC_DATA  input  DATA_W  current intensity sample, held stable by the source
- CNT_L  output  1  horizontal sweep still pending
- CNT_RU  output  1  return steps still pending
- CNT_D  output  1  vertical sweep still pending
- STEP_TICK  output  1  one-cycle pulse on every counted step
- MAX_H_POS  output  $clog2(SWEEP_STEPS+1)  horizontal peak step index
- MAX_V_POS  output  $clog2(SWEEP_STEPS+1)  vertical peak step index
- MAX_VAL  output  DATA_W  peak intensity of the current or last sweep

Behaviour:
- State registers:
  - h_done, v_done flags.
  - step_cnt, ret_cnt with width $clog2(SWEEP_STEPS+1).
  - prescaler with width $clog2(STEP_DIV).
  - max_val, max_pos.
- Reset (RST or CNT_RST high at a CLK edge): all registers cleared to 0; STEP_TICK is 0.
  - Outputs after reset: CNT_L=1, CNT_D=1, CNT_RU=0, positions 0, MAX_VAL 0.
- Output decode (combinational from registers, so they are valid in the same cycle the FSM samples them):
  - CNT_L = ~h_done
  - CNT_D = ~v_done
  - CNT_RU = (ret_cnt != 0)
- Active phase (priority order; only one is active, all others idle):
  - H_SWEEP: HS & ~h_done.
  - V_SWEEP: VS & h_done & ~v_done.
  - RETURN: MC & (ret_cnt != 0).
  - VS while ~h_done is ignored. HS and VS high together: HS wins.
- Prescaler:
  - Increments each cycle while a phase is active.
  - On reaching STEP_DIV-1 it wraps to 0 and STEP_TICK pulses for 1 cycle.
  - Forced to 0 whenever no phase is active, so the first tick of any phase comes exactly STEP_DIV cycles after the phase activates.
- Sweep tick (H_SWEEP or V_SWEEP):
  - step_cnt <= step_cnt+1; call the new value k.
  - If ADC_DATA > max_val (strict, unsigned): max_val <= ADC_DATA and max_pos <= k. Ties keep the earlier position.
  - When k == SWEEP_STEPS, on that same tick:
    - Set the phase's done flag.
    - Copy max_pos to MAX_H_POS or MAX_V_POS.
    - ret_cnt <= SWEEP_STEPS - max_pos, using the max_pos updated by this tick.
    - step_cnt <= 0.
  - Latency: done flag rises SWEEP_STEPS*STEP_DIV cycles after the phase activates.
- Starting a V_SWEEP: max_val and max_pos clear to 0 on the first cycle V_SWEEP is active. MAX_H_POS is retained.
- Return tick: ret_cnt <= ret_cnt-1. CNT_RU falls in the cycle after ret_cnt reaches 0.
- Sweep with all-zero samples: max_pos=0, so the return count is SWEEP_STEPS.
- Peak at step SWEEP_STEPS: ret_cnt=0, so CNT_RU is never asserted and the FSM skips the return phase.
- Phase enable dropped mid-step: the prescaler zeroes, step_cnt and ret_cnt hold, and the step restarts from full STEP_DIV when the enable returns.
- After v_done, the block stays quiescent until RST or CNT_RST.

Optional Feature:
- Macro: MAX_HYST_EN.
- Defined: a new maximum requires ADC_DATA > max_val + HYST, with the sum computed at DATA_W+1 bits so it does not overflow. The first tick of each sweep always loads unconditionally.
- Undefined: the plain strict comparison above applies; the HYST parameter is unused.

Test Plan (STEP_DIV=4, SWEEP_STEPS=8, DATA_W=12, macro undefined unless stated):
- Release RST, hold HS=VS=MC=0 -> CNT_L=1, CNT_D=1, CNT_RU=0, no STEP_TICK.
- HS=1, samples 10,20,90,40,90,5,5,5 at ticks 1..8 -> STEP_TICK every 4 cycles; CNT_L falls after cycle 32; MAX_H_POS=3; MAX_VAL=90; CNT_RU=1.
- Then HS=0, MC=1 -> 5 STEP_TICK pulses; CNT_RU falls 20 cycles after MC rises.
- MC=0, VS=1, samples peak 300 at tick 8 -> MAX_V_POS=8; CNT_D falls; CNT_RU stays 0; MAX_H_POS still 3.
- Pulse CNT_RST at mid vertical sweep (tick 4) -> next cycle all counters 0, CNT_L=1, CNT_D=1, CNT_RU=0.
- MAX_HYST_EN defined, HYST=8, samples 100,105,109,108,0,0,0,0 -> MAX_H_POS=3, MAX_VAL=109 (105 rejected).
